// File: rtl/ucode_seq_pkg.sv
// Shared definitions for the microcode sequencer and its decode-ROM users:
// sequencer states, default opcode/step widths and ROM address width.
package ucode_seq_pkg;

    localparam int OPW_DEF   = 8;
    localparam int STEPW_DEF = 2;

    function automatic int addr_width(input int opw, input int stepw);
        return opw + stepw;
    endfunction

    localparam int AW_DEF = addr_width(OPW_DEF, STEPW_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/ucode_seq_if.sv
// Sequencer-facing bundle: instruction handshake, ROM address and ROM word
// control bits, datapath stall and status flags.
interface ucode_seq_if
    import ucode_seq_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int STEPW = STEPW_DEF
);
    localparam int AW = addr_width(OPW, STEPW);

    logic           run;
    logic           ir_valid;
    logic [OPW-1:0] ir_op;
    logic           ir_ready;
    logic [AW-1:0]  uop_addr;
    logic           uop_end;
    logic           uop_halt;
    logic           stall;
    logic           uop_active;
    logic           halted;
    logic           overrun;

    modport master (
        output run, ir_valid, ir_op, uop_end, uop_halt, stall,
        input  ir_ready, uop_addr, uop_active, halted, overrun
    );

    modport slave (
        input  run, ir_valid, ir_op, uop_end, uop_halt, stall,
        output ir_ready, uop_addr, uop_active, halted, overrun
    );

endinterface

// File: rtl/ucode_next_addr.sv
// Combinational next-state / next-address logic of the microcode sequencer.
// Overrun handling is selected by UCODE_SEQ_OVERRUN_TRAP_EN (defined: trap to HALT).
module ucode_next_addr
    import ucode_seq_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int STEPW = STEPW_DEF
) (
    input  seq_state_t             state,
    input  logic [OPW-1:0]         op_q,
    input  logic [STEPW-1:0]       step_q,
    input  logic                   run,
    input  logic                   ir_valid,
    input  logic [OPW-1:0]         ir_op,
    input  logic                   uop_end,
    input  logic                   uop_halt,
    input  logic                   stall,
    output seq_state_t             next_state,
    output logic [OPW-1:0]         next_op,
    output logic [STEPW-1:0]       next_step,
    output logic                   set_overrun,
    output logic                   ir_ready,
    output logic                   uop_active,
    output logic [OPW+STEPW-1:0]   uop_addr
);
    localparam logic [STEPW-1:0] LAST_STEP = '1;

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state  = state;
        next_op     = op_q;
        next_step   = step_q;
        set_overrun = 1'b0;
        ir_ready    = 1'b0;
        uop_active  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                ir_ready = run;
                if (run && ir_valid) begin
                    next_op    = ir_op;
                    next_step  = '0;
                    next_state = ST_EXEC;
                end else if (!run) begin
                    next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                uop_active = !stall;
                if (!stall) begin
                    if (uop_halt) begin
                        next_state = ST_HALT;
                    end else if (uop_end) begin
                        next_state = run ? ST_FETCH : ST_IDLE;
                    end else if (step_q == LAST_STEP) begin
                        set_overrun = 1'b1;
`ifdef UCODE_SEQ_OVERRUN_TRAP_EN
                        next_state  = ST_HALT;
`else
                        next_state  = run ? ST_FETCH : ST_IDLE;
`endif
                    end else begin
                        next_step = step_q + STEPW'(1);
                    end
                end
            end
            ST_HALT: begin
                if (!run) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Equals {op_q, step_q} except on a transition, so the ROM latches the new word in time.
    assign uop_addr = {next_op, next_step};

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer top: holds state, op_q/step_q (shadow of the ROM address
// register) and the sticky overrun flag. Build option: UCODE_SEQ_OVERRUN_TRAP_EN.
module ucode_seq
    import ucode_seq_pkg::*;
#(
    parameter int OPW   = OPW_DEF,
    parameter int STEPW = STEPW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    ucode_seq_if.slave  bus
);
    seq_state_t       state, next_state;
    logic [OPW-1:0]   op_q, next_op;
    logic [STEPW-1:0] step_q, next_step;
    logic             set_overrun;
    logic             overrun_q;
    logic             halted_q;

    ucode_next_addr #(
        .OPW   (OPW),
        .STEPW (STEPW)
    ) u_next_addr (
        .state       (state),
        .op_q        (op_q),
        .step_q      (step_q),
        .run         (bus.run),
        .ir_valid    (bus.ir_valid),
        .ir_op       (bus.ir_op),
        .uop_end     (bus.uop_end),
        .uop_halt    (bus.uop_halt),
        .stall       (bus.stall),
        .next_state  (next_state),
        .next_op     (next_op),
        .next_step   (next_step),
        .set_overrun (set_overrun),
        .ir_ready    (bus.ir_ready),
        .uop_active  (bus.uop_active),
        .uop_addr    (bus.uop_addr)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state    <= next_state;
            op_q     <= next_op;
            step_q   <= next_step;
            halted_q <= (next_state == ST_HALT);
            if (set_overrun) overrun_q <= 1'b1;
        end
    end

    assign bus.halted  = halted_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq: directed scenarios with fixed expectations
// plus a randomized run against a cycle-level behavioural model.
module tb_ucode_seq;
    import ucode_seq_pkg::*;

`ifdef UCODE_SEQ_OVERRUN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    ucode_seq_if #(.OPW(8), .STEPW(2)) bus ();

    ucode_seq #(.OPW(8), .STEPW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what the sequencer is doing, as plain flags and integers.
    bit m_fetch, m_exec, m_stop, m_ovr;
    int m_op, m_step;

    task automatic cyc(input bit r, input bit v, input logic [7:0] op,
                       input bit e, input bit h, input bit s);
        @(negedge clk);
        bus.run = r; bus.ir_valid = v; bus.ir_op = op;
        bus.uop_end = e; bus.uop_halt = h; bus.stall = s;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(1, 1, 8'hAB, 1, 1, 0);
        n_vec++; if (bus.ir_ready !== 1'b0)   begin n_miss++; $display("FAIL rst_ready: got %b want 0", bus.ir_ready); end
        n_vec++; if (bus.uop_addr !== 10'h000) begin n_miss++; $display("FAIL rst_addr: got %h want 000", bus.uop_addr); end
        n_vec++; if (bus.uop_active !== 1'b0) begin n_miss++; $display("FAIL rst_active: got %b want 0", bus.uop_active); end
        n_vec++; if (bus.halted !== 1'b0)     begin n_miss++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
        n_vec++; if (bus.overrun !== 1'b0)    begin n_miss++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
        bus.run = 0; bus.ir_valid = 0; bus.uop_end = 0; bus.uop_halt = 0;
        #1 rst = 1'b1;
    endtask

    task automatic test_fetch_exec();
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.ir_ready !== 1'b0) begin n_miss++; $display("FAIL idle_ready: got %b want 0", bus.ir_ready); end
        cyc(1, 1, 8'h12, 0, 0, 0);
        n_vec++; if (bus.ir_ready !== 1'b1)    begin n_miss++; $display("FAIL fetch_ready: got %b want 1", bus.ir_ready); end
        n_vec++; if (bus.uop_addr !== 10'h048) begin n_miss++; $display("FAIL fetch_addr: got %h want 048", bus.uop_addr); end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_active !== 1'b1)  begin n_miss++; $display("FAIL exec0_active: got %b want 1", bus.uop_active); end
        n_vec++; if (bus.uop_addr !== 10'h049) begin n_miss++; $display("FAIL exec0_addr: got %h want 049", bus.uop_addr); end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h04A) begin n_miss++; $display("FAIL exec1_addr: got %h want 04A", bus.uop_addr); end
        cyc(1, 0, 8'h00, 1, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h04A) begin n_miss++; $display("FAIL exec2_end_addr: got %h want 04A", bus.uop_addr); end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.ir_ready !== 1'b1)   begin n_miss++; $display("FAIL refetch_ready: got %b want 1", bus.ir_ready); end
        n_vec++; if (bus.uop_active !== 1'b0) begin n_miss++; $display("FAIL refetch_active: got %b want 0", bus.uop_active); end
    endtask

    task automatic test_stall();
        cyc(1, 1, 8'h12, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h049) begin n_miss++; $display("FAIL stall_pre_addr: got %h want 049", bus.uop_addr); end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 1, 1, 1);
            n_vec++; if (bus.uop_addr !== 10'h049) begin n_miss++; $display("FAIL stall_addr[%0d]: got %h want 049", i, bus.uop_addr); end
            n_vec++; if (bus.uop_active !== 1'b0)  begin n_miss++; $display("FAIL stall_active[%0d]: got %b want 0", i, bus.uop_active); end
        end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h04A) begin n_miss++; $display("FAIL stall_post_addr: got %h want 04A", bus.uop_addr); end
        n_vec++; if (bus.uop_active !== 1'b1)  begin n_miss++; $display("FAIL stall_post_active: got %b want 1", bus.uop_active); end
        cyc(1, 0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_halt();
        cyc(1, 1, 8'h34, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h0D0) begin n_miss++; $display("FAIL halt_fetch_addr: got %h want 0D0", bus.uop_addr); end
        cyc(1, 0, 8'h00, 1, 1, 0);
        n_vec++; if (bus.uop_addr !== 10'h0D0) begin n_miss++; $display("FAIL halt_word_addr: got %h want 0D0", bus.uop_addr); end
        cyc(1, 1, 8'h77, 1, 0, 0);
        n_vec++; if (bus.halted !== 1'b1)     begin n_miss++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
        n_vec++; if (bus.ir_ready !== 1'b0)   begin n_miss++; $display("FAIL halt_ready: got %b want 0", bus.ir_ready); end
        n_vec++; if (bus.uop_active !== 1'b0) begin n_miss++; $display("FAIL halt_active: got %b want 0", bus.uop_active); end
        cyc(0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.halted !== 1'b1) begin n_miss++; $display("FAIL halt_hold: got %b want 1", bus.halted); end
        cyc(0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.halted !== 1'b0) begin n_miss++; $display("FAIL halt_exit: got %b want 0", bus.halted); end
    endtask

    task automatic test_overrun();
        logic [9:0] want;
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'hFF, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h3FC) begin n_miss++; $display("FAIL ovr_fetch_addr: got %h want 3FC", bus.uop_addr); end
        for (int s = 0; s < 3; s++) begin
            cyc(1, 0, 8'h00, 0, 0, 0);
            want = 10'h3FD + 10'(s);
            n_vec++; if (bus.uop_addr !== want) begin n_miss++; $display("FAIL ovr_step%0d_addr: got %h want %h", s, bus.uop_addr, want); end
        end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h3FF) begin n_miss++; $display("FAIL ovr_last_addr: got %h want 3FF", bus.uop_addr); end
        n_vec++; if (bus.overrun !== 1'b0)     begin n_miss++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.overrun !== 1'b1)   begin n_miss++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        n_vec++; if (bus.halted !== TRAP)    begin n_miss++; $display("FAIL ovr_halted: got %b want %b", bus.halted, TRAP); end
        n_vec++; if (bus.ir_ready !== !TRAP) begin n_miss++; $display("FAIL ovr_ready: got %b want %b", bus.ir_ready, !TRAP); end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 8'h00, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h56, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h158) begin n_miss++; $display("FAIL ar_fetch_addr: got %h want 158", bus.uop_addr); end
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (bus.uop_addr !== 10'h15B) begin n_miss++; $display("FAIL ar_step2_addr: got %h want 15B", bus.uop_addr); end
        #1 rst = 1'b0;
        #1;
        n_vec++; if (bus.uop_addr !== 10'h000) begin n_miss++; $display("FAIL ar_addr: got %h want 000", bus.uop_addr); end
        n_vec++; if (bus.uop_active !== 1'b0)  begin n_miss++; $display("FAIL ar_active: got %b want 0", bus.uop_active); end
        n_vec++; if (bus.overrun !== 1'b0)     begin n_miss++; $display("FAIL ar_overrun: got %b want 0", bus.overrun); end
        n_vec++; if (bus.ir_ready !== 1'b0)    begin n_miss++; $display("FAIL ar_ready: got %b want 0", bus.ir_ready); end
        @(negedge clk);
        bus.run = 0; bus.ir_valid = 0;
        #1 rst = 1'b1;
        cyc(1, 1, 8'h56, 0, 0, 0);
        n_vec++; if (bus.ir_ready !== 1'b0) begin n_miss++; $display("FAIL ar_idle_ready: got %b want 0", bus.ir_ready); end
        cyc(1, 1, 8'h56, 0, 0, 0);
        n_vec++; if (bus.ir_ready !== 1'b1)    begin n_miss++; $display("FAIL ar_refetch_ready: got %b want 1", bus.ir_ready); end
        n_vec++; if (bus.uop_addr !== 10'h158) begin n_miss++; $display("FAIL ar_refetch_addr: got %h want 158", bus.uop_addr); end
    endtask

    task automatic test_random();
        bit r, v, e, h, s;
        logic [7:0] op;
        int  e_addr;
        bit  e_ready, e_active;
        @(negedge clk);
        rst = 1'b0; bus.run = 0; bus.ir_valid = 0; bus.uop_end = 0; bus.uop_halt = 0; bus.stall = 0;
        #2 rst = 1'b1;
        m_fetch = 0; m_exec = 0; m_stop = 0; m_ovr = 0; m_op = 0; m_step = 0;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) < 85);
            v  = ($urandom_range(0, 99) < 50);
            e  = ($urandom_range(0, 99) < 30);
            h  = ($urandom_range(0, 99) < 4);
            s  = ($urandom_range(0, 99) < 20);
            op = 8'($urandom_range(0, 255));
            cyc(r, v, op, e, h, s);
            e_ready  = m_fetch && r;
            e_active = m_exec && !s;
            if (m_fetch && r && v)                         e_addr = int'(op) * 4;
            else if (m_exec && !s && !h && !e && m_step < 3) e_addr = m_op * 4 + m_step + 1;
            else                                           e_addr = m_op * 4 + m_step;
            n_vec++; if (bus.ir_ready !== e_ready)   begin n_miss++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.ir_ready, e_ready); end
            n_vec++; if (bus.uop_active !== e_active) begin n_miss++; $display("FAIL rnd_active@%0d: got %b want %b", n, bus.uop_active, e_active); end
            n_vec++; if (bus.halted !== m_stop)      begin n_miss++; $display("FAIL rnd_halted@%0d: got %b want %b", n, bus.halted, m_stop); end
            n_vec++; if (bus.overrun !== m_ovr)      begin n_miss++; $display("FAIL rnd_overrun@%0d: got %b want %b", n, bus.overrun, m_ovr); end
            n_vec++; if (bus.uop_addr !== 10'(e_addr)) begin n_miss++; $display("FAIL rnd_addr@%0d: got %h want %h", n, bus.uop_addr, 10'(e_addr)); end
            // Advance the model to what should hold after this clock edge.
            if (m_stop) begin
                if (!r) m_stop = 0;
            end else if (m_exec) begin
                if (!s) begin
                    if (h) begin
                        m_exec = 0; m_stop = 1;
                    end else if (e) begin
                        m_exec = 0; m_fetch = r;
                    end else if (m_step == 3) begin
                        m_ovr = 1; m_exec = 0;
                        if (TRAP) m_stop = 1; else m_fetch = r;
                    end else begin
                        m_step++;
                    end
                end
            end else if (m_fetch) begin
                if (r && v) begin
                    m_op = int'(op); m_step = 0; m_fetch = 0; m_exec = 1;
                end else if (!r) begin
                    m_fetch = 0;
                end
            end else if (r) begin
                m_fetch = 1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.run = 0; bus.ir_valid = 0; bus.ir_op = '0;
        bus.uop_end = 0; bus.uop_halt = 0; bus.stall = 0;
        test_reset();
        test_fetch_exec();
        test_stall();
        test_halt();
        test_overrun();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameter OPW, default 8, opcode width.
REQ-002 Parameter STEPW, default 2, microstep index width; ROM address width AW = OPW+STEPW (10 at defaults).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  enable; 1 = fetch and execute instructions.
REQ-006 ir_valid  input  1  opcode on ir_op is valid.
REQ-007 ir_op  input  OPW  instruction opcode.
REQ-008 ir_ready  output  1  sequencer accepts an opcode this cycle.
REQ-009 uop_addr  output  AW  next microinstruction address, driven combinationally into the decode ROM address register.
REQ-010 uop_end  input  1  end-of-instruction bit of the current ROM word.
REQ-011 uop_halt  input  1  halt bit of the current ROM word.
REQ-012 stall  input  1  datapath busy; current microinstruction must repeat.
REQ-013 uop_active  output  1  current ROM word commits this cycle.
REQ-014 halted  output  1  sequencer is in HALT.
REQ-015 overrun  output  1  sticky: instruction exceeded 2^STEPW microsteps.

Function
REQ-016 States IDLE, FETCH, EXEC, HALT; the ROM's registered address is the microPC, and the sequencer keeps a shadow copy cur_addr = {op_q, step_q} that always equals the address the ROM latched.
REQ-017 uop_addr = cur_addr in every state except a transition cycle, where it carries the new address, so the ROM word for a state is valid in the first cycle of that state (zero bubble).
REQ-018 IDLE: ir_ready=0, uop_active=0; run=1 -> FETCH.
REQ-019 FETCH: ir_ready=run; ir_valid&ir_ready -> latch op_q=ir_op, step_q=0, uop_addr={ir_op,0}, next EXEC; run=0 -> IDLE.
REQ-020 EXEC: uop_active = ~stall; priority per cycle: stall (hold, uop_addr=cur_addr) > uop_halt (-> HALT) > uop_end (-> run ? FETCH : IDLE) > step_q==2^STEPW-1 (overrun) > step_q+1.
REQ-021 Step increment never wraps within an instruction; step_q is reset to 0 only on opcode accept.
REQ-022 Overrun (last step without uop_end): set overrun, behaviour per REQ-031/032.
REQ-023 HALT: halted=1, ir_ready=0, uop_active=0; leaves to IDLE only when run=0.
REQ-024 run deasserted during EXEC: current instruction completes; then IDLE.
REQ-025 uop_end/uop_halt ignored outside EXEC.

Reset
REQ-026 rst=0 asynchronously forces IDLE, op_q=0, step_q=0, overrun=0.
REQ-027 During reset: uop_addr=0, ir_ready=0, uop_active=0, halted=0.
REQ-028 Reset mid-instruction abandons it; no partial state survives; first fetch after release needs run=1 for one IDLE cycle.

Configuration
REQ-029 Macro UCODE_SEQ_OVERRUN_TRAP_EN selects overrun handling.
REQ-030 overrun flag is set in both builds.
REQ-031 Defined: overrun -> HALT (halted=1) in the cycle after the last step.
REQ-032 Undefined: overrun treated as implicit uop_end (-> FETCH/IDLE), execution continues.

Structure
REQ-033 Package ucode_seq_pkg holds state enum, OPW/STEPW defaults and AW derivation; decode ROM users import it.
REQ-034 One sub-module ucode_next_addr: combinational next-state/next-address logic; state and cur_addr registers stay in ucode_seq.

Verification
REQ-035 Reset release, run=1, ir_op=8'h12 valid -> uop_addr 10'h048 in that cycle, EXEC next, uop_active=1.
REQ-036 op 8'h12, uop_end on step 2 -> addresses 048,049,04A, then FETCH, ir_ready=1.
REQ-037 stall=1 for 3 cycles at step 1 -> uop_addr held 049, uop_active=0, then 04A.
REQ-038 uop_halt with uop_end same cycle -> HALT, halted=1; run=0 -> IDLE.
REQ-039 op 8'hFF, no uop_end through step 3 -> overrun=1; TRAP build: HALT; else FETCH.
REQ-040 rst=0 mid-EXEC at step 2 -> immediately IDLE, uop_addr=0, overrun=0.
